register_file_mp: RTL and testbench

Parametrised multi-port successor to the two-read/one-write MIPS register file, sitting between decode (reads) and writeback (writes) in the pipelined core. Provides READ_PORTS combinational read ports and WRITE_PORTS clocked write ports over 2^ADDR_WIDTH registers, with register 0 hardwired to zero. Adds a per-register pending scoreboard so decode can stall on load-use and multi-cycle hazards. Optionally forwards same-cycle writes to the read ports.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/register_file_mp_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/register_file_mp.sv | 86 ++++++++
 tb/tb_register_file_mp.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the multi-port register file.
// The optional same-cycle bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT  = 32;
    localparam int unsigned ADDR_WIDTH_DEFAULT  = 5;
    localparam int unsigned READ_PORTS_DEFAULT  = 2;
    localparam int unsigned WRITE_PORTS_DEFAULT = 2;

    typedef logic [ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH_DEFAULT-1:0] reg_data_t;

    // Register 0 reads as zero and ignores writes and reservations.
    localparam reg_addr_t ZERO_REG = reg_addr_t'(0);

endpackage

// File: rtl/register_file_mp_if.sv
// Read/write/reserve bus between the pipeline (master) and register_file_mp (slave).
interface register_file_mp_if #(
    parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH  = regfile_pkg::ADDR_WIDTH_DEFAULT,
    parameter int READ_PORTS  = regfile_pkg::READ_PORTS_DEFAULT,
    parameter int WRITE_PORTS = regfile_pkg::WRITE_PORTS_DEFAULT
);

    logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  selector_out;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  value_out;
    logic [READ_PORTS-1:0]                  pending_out;
    logic [WRITE_PORTS-1:0]                 write_enable;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] selector_in;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] value_in;
    logic                                   reserve_enable;
    logic [ADDR_WIDTH-1:0]                  reserve_selector;

    modport master (
        output selector_out, write_enable, selector_in, value_in,
               reserve_enable, reserve_selector,
        input  value_out, pending_out
    );

    modport slave (
        input  selector_out, write_enable, selector_in, value_in,
               reserve_enable, reserve_selector,
        output value_out, pending_out
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending vector: writes clear, a reserve sets, and a reserve
// overrides a clear to the same register in the same cycle.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int WRITE_PORTS = WRITE_PORTS_DEFAULT
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [WRITE_PORTS-1:0]                 write_enable,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] selector_in,
    input  logic                                   reserve_enable,
    input  logic [ADDR_WIDTH-1:0]                  reserve_selector,
    output logic [(1<<ADDR_WIDTH)-1:0]             pending_r
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] clear_s;
    logic [DEPTH-1:0] set_s;
    logic [DEPTH-1:0] pending_next_s;

    // Build clear/set masks; bit 0 is masked so register 0 never goes pending.
    always_comb begin
        clear_s = {DEPTH{1'b0}};
        set_s   = {DEPTH{1'b0}};
        for (int w = 0; w < WRITE_PORTS; w++) begin
            clear_s[selector_in[w]] = clear_s[selector_in[w]] | write_enable[w];
        end
        set_s[reserve_selector] = reserve_enable;
        pending_next_s = ((pending_r & ~clear_s) | set_s) & ~DEPTH'(1);
    end

    // Pending vector register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with hardwired-zero r0 and a pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mp import regfile_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int READ_PORTS  = READ_PORTS_DEFAULT,
    parameter int WRITE_PORTS = WRITE_PORTS_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    register_file_mp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]      pending_r;

    // Data array; ports are applied in ascending order so the highest port wins a collision.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (bus.write_enable[w] && (bus.selector_in[w] != ADDR_WIDTH'(ZERO_REG))) begin
                    regs_r[bus.selector_in[w]] <= bus.value_in[w];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WRITE_PORTS (WRITE_PORTS)
    ) u_scoreboard (
        .clock            (clock),
        .reset_n          (reset_n),
        .write_enable     (bus.write_enable),
        .selector_in      (bus.selector_in),
        .reserve_enable   (bus.reserve_enable),
        .reserve_selector (bus.reserve_selector),
        .pending_r        (pending_r)
    );

    genvar r;
    generate
        for (r = 0; r < READ_PORTS; r++) begin : g_read
            logic [DATA_WIDTH-1:0] read_val_s;
            logic                  read_pend_s;
            logic                  zero_sel_s;
`ifdef REGFILE_BYPASS_EN
            logic                  byp_hit_s;
            logic [DATA_WIDTH-1:0] byp_val_s;
            logic                  rsv_hit_s;
`endif

            // Read mux, optional forwarding, then forcing to zero for r0 or reset.
            always_comb begin
                zero_sel_s  = (!reset_n) || (bus.selector_out[r] == ADDR_WIDTH'(ZERO_REG));
                read_val_s  = regs_r[bus.selector_out[r]];
                read_pend_s = pending_r[bus.selector_out[r]];
`ifdef REGFILE_BYPASS_EN
                byp_hit_s = 1'b0;
                byp_val_s = {DATA_WIDTH{1'b0}};
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    byp_val_s = (bus.write_enable[w] && (bus.selector_in[w] == bus.selector_out[r]))
                                ? bus.value_in[w] : byp_val_s;
                    byp_hit_s = byp_hit_s
                                | (bus.write_enable[w] & (bus.selector_in[w] == bus.selector_out[r]));
                end
                rsv_hit_s   = bus.reserve_enable && (bus.reserve_selector == bus.selector_out[r]);
                read_val_s  = byp_hit_s ? byp_val_s : read_val_s;
                read_pend_s = (byp_hit_s && !rsv_hit_s) ? 1'b0 : read_pend_s;
`endif
                read_val_s  = zero_sel_s ? {DATA_WIDTH{1'b0}} : read_val_s;
                read_pend_s = zero_sel_s ? 1'b0 : read_pend_s;
            end

            assign bus.value_out[r]   = read_val_s;
            assign bus.pending_out[r] = read_pend_s;
        end
    endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios plus random traffic
// against an array-based reference model.
module tb_register_file_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];

    register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bif ();

    register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clock = ~clock;

    task automatic idle();
        bif.write_enable     = '0;
        bif.selector_in      = '0;
        bif.value_in         = '0;
        bif.reserve_enable   = 1'b0;
        bif.reserve_selector = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [DW-1:0] val);
        bif.write_enable[port] = 1'b1;
        bif.selector_in[port]  = AW'(addr);
        bif.value_in[port]     = val;
    endtask

    task automatic rsv(input int addr);
        bif.reserve_enable   = 1'b1;
        bif.reserve_selector = AW'(addr);
    endtask

    // Expected read value given the model state and the current inputs.
    function automatic logic [DW-1:0] exp_value(input logic [AW-1:0] sel);
        logic [DW-1:0] v;
        v = m_regs[sel];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < WP; w++)
            if (bif.write_enable[w] && bif.selector_in[w] == sel) v = bif.value_in[w];
`endif
        if (!reset_n || sel == 0) v = '0;
        return v;
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] sel);
        bit p;
        p = m_pend[sel];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < WP; w++)
            if (bif.write_enable[w] && bif.selector_in[w] == sel &&
                !(bif.reserve_enable && bif.reserve_selector == sel)) p = 1'b0;
`endif
        if (!reset_n || sel == 0) p = 1'b0;
        return p;
    endfunction

    // Advance the model by one edge with the currently driven inputs, then the DUT.
    task automatic tick();
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int w = 0; w < WP; w++)
                if (bif.write_enable[w] && bif.selector_in[w] != 0) begin
                    m_regs[bif.selector_in[w]] = bif.value_in[w];
                    m_pend[bif.selector_in[w]] = 1'b0;
                end
            if (bif.reserve_enable && bif.reserve_selector != 0)
                m_pend[bif.reserve_selector] = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        wr(0, 5, 32'hDEAD);
        tick();
        idle();
        bif.selector_out[0] = AW'(5);
        #1;
        checks++;
        if (bif.value_out[0] !== 32'hDEAD) begin
            errors++; $display("FAIL pre_reset_r5 got %h want %h", bif.value_out[0], 32'hDEAD);
        end
        reset_n = 1'b0;
        rsv(5);
        tick();
        tick();
        #1;
        checks++;
        if (bif.value_out[0] !== 32'h0 || bif.pending_out !== 2'b00) begin
            errors++; $display("FAIL during_reset got %h/%b want 0/00", bif.value_out[0], bif.pending_out);
        end
        reset_n = 1'b1;
        idle();
        tick();
        checks++;
        if (bif.value_out[0] !== 32'h0 || bif.pending_out[0] !== 1'b0) begin
            errors++; $display("FAIL after_reset_r5 got %h/%b want 0/0", bif.value_out[0], bif.pending_out[0]);
        end
    endtask

    task automatic test_basic();
        idle();
        wr(0, 1, 32'd10);
        tick();
        idle();
        wr(0, 2, 32'd20);
        bif.selector_out[0] = AW'(1);
        #1;
        checks++;
        if (bif.value_out[0] !== 32'd10) begin
            errors++; $display("FAIL basic_r1 got %0d want 10", bif.value_out[0]);
        end
        tick();
        idle();
        bif.selector_out[1] = AW'(2);
        #1;
        checks++;
        if (bif.value_out[0] !== 32'd10 || bif.value_out[1] !== 32'd20) begin
            errors++; $display("FAIL basic_r1_r2 got %0d/%0d want 10/20", bif.value_out[0], bif.value_out[1]);
        end
        wr(0, 0, 32'd10);
        rsv(0);
        tick();
        idle();
        bif.selector_out[0] = AW'(0);
        bif.selector_out[1] = AW'(0);
        #1;
        checks++;
        if (bif.value_out !== '0 || bif.pending_out !== 2'b00) begin
            errors++; $display("FAIL r0_zero got %h/%b want 0/00", bif.value_out, bif.pending_out);
        end
    endtask

    task automatic test_collision();
        idle();
        wr(0, 3, 32'h11);
        wr(1, 3, 32'h22);
        tick();
        idle();
        bif.selector_out[1] = AW'(3);
        #1;
        checks++;
        if (bif.value_out[1] !== 32'h22) begin
            errors++; $display("FAIL collision_r3 got %h want 22", bif.value_out[1]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv(7);
        bif.selector_out[0] = AW'(7);
        tick();
        idle();
        #1;
        checks++;
        if (bif.pending_out[0] !== 1'b1) begin
            errors++; $display("FAIL reserve_r7 got %b want 1", bif.pending_out[0]);
        end
        wr(1, 7, 32'd5);
        tick();
        idle();
        #1;
        checks++;
        if (bif.pending_out[0] !== 1'b0 || bif.value_out[0] !== 32'd5) begin
            errors++; $display("FAIL clear_r7 got %b/%0d want 0/5", bif.pending_out[0], bif.value_out[0]);
        end
        wr(0, 7, 32'd9);
        rsv(7);
        tick();
        idle();
        #1;
        checks++;
        if (bif.pending_out[0] !== 1'b1 || bif.value_out[0] !== 32'd9) begin
            errors++; $display("FAIL reserve_wins_r7 got %b/%0d want 1/9", bif.pending_out[0], bif.value_out[0]);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        idle();
        wr(0, 4, 32'h1);
        tick();
        idle();
        wr(0, 4, 32'h44);
        bif.selector_out[0] = AW'(4);
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h44;
`else
        want = 32'h1;
`endif
        checks++;
        if (bif.value_out[0] !== want) begin
            errors++; $display("FAIL bypass_same_cycle got %h want %h", bif.value_out[0], want);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bif.value_out[0] !== 32'h44) begin
            errors++; $display("FAIL bypass_next_cycle got %h want 44", bif.value_out[0]);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rsv(9);
        bif.selector_out[1] = AW'(9);
        tick();
        idle();
        #1;
        checks++;
        if (bif.pending_out[1] !== 1'b1) begin
            errors++; $display("FAIL mid_reserve_r9 got %b want 1", bif.pending_out[1]);
        end
        reset_n = 1'b0;
        wr(0, 9, 32'h99);
        rsv(9);
        tick();
        reset_n = 1'b1;
        idle();
        #1;
        checks++;
        if (bif.pending_out[1] !== 1'b0 || bif.value_out[1] !== 32'h0) begin
            errors++; $display("FAIL mid_reset_r9 got %b/%h want 0/0", bif.pending_out[1], bif.value_out[1]);
        end
        wr(1, 9, 32'h77);
        tick();
        idle();
        #1;
        checks++;
        if (bif.pending_out[1] !== 1'b0 || bif.value_out[1] !== 32'h77) begin
            errors++; $display("FAIL post_reset_write_r9 got %b/%h want 0/77", bif.pending_out[1], bif.value_out[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            for (int w = 0; w < WP; w++) begin
                bif.write_enable[w] = 1'($urandom_range(0, 1));
                bif.selector_in[w]  = AW'($urandom_range(0, 11));
                bif.value_in[w]     = $urandom();
            end
            bif.reserve_enable   = 1'($urandom_range(0, 1));
            bif.reserve_selector = AW'($urandom_range(0, 11));
            for (int r = 0; r < RP; r++)
                bif.selector_out[r] = AW'($urandom_range(0, 11));
            #1;
            for (int r = 0; r < RP; r++) begin
                checks++;
                if (bif.value_out[r] !== exp_value(bif.selector_out[r]) ||
                    bif.pending_out[r] !== exp_pend(bif.selector_out[r])) begin
                    errors++;
                    $display("FAIL random_port%0d cyc %0d sel %0d got %h/%b want %h/%b", r, n,
                             bif.selector_out[r], bif.value_out[r], bif.pending_out[r],
                             exp_value(bif.selector_out[r]), exp_pend(bif.selector_out[r]));
                end
            end
            tick();
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        bif.selector_out = '0;
        reset_n = 1'b0;
        #2;
        tick();
        reset_n = 1'b1;
        test_reset();
        test_basic();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
